uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 118 +++++++++++
 tb/tb_uart_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter. A request is accepted only from IDLE;
// tx, busy and the debug frame counter all come straight from flops.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        new_data,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_stop_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic [15:0]   r_frames;

  logic w_bit_end;
  assign w_bit_end = (r_clk_cnt == CNT_MAX);

  // Frame sequencer: bit timing, shifting, line drive and frame accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_frames   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          r_tx      <= 1'b1;
          if (new_data) begin
            // Start bit goes out on the accepting edge itself.
            r_shift   <= data;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_idx <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx       <= 1'b1;
              r_stop_idx <= 1'b0;
              r_state    <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_stop_idx == STOP_LAST) begin
              // A request on this edge is deliberately not seen; IDLE takes it.
              r_busy   <= 1'b0;
              r_frames <= r_frames + 16'd1;
              r_state  <= S_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_clk_cnt <= '0;
          r_tx      <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign tx          = r_tx;
  assign busy        = r_busy;
  assign frames_sent = r_frames;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx at 4 clocks/bit, one and two stop bits.
module tb_uart_tx;

  logic        clk, rst_n;
  logic [7:0]  data1, data2;
  logic        nd1, nd2;
  logic        tx1, tx2, busy1, busy2;
  logic [15:0] fs1, fs2;

  int errors = 0;
  int checks = 0;

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data(data1), .new_data(nd1),
    .tx(tx1), .busy(busy1), .frames_sent(fs1));

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data(data2), .new_data(nd2),
    .tx(tx2), .busy(busy2), .frames_sent(fs2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line: idle-high everywhere except one frame starting at cycle off.
  function automatic logic [127:0] frame(input logic [7:0] d, input int stops, input int off);
    logic [127:0] r;
    logic b;
    r = '1;
    for (int k = 0; k < 9 + stops; k++) begin
      if (k == 0)      b = 1'b0;
      else if (k <= 8) b = d[k-1];
      else             b = 1'b1;
      for (int c = 0; c < 4; c++) r[off + 4*k + c] = b;
    end
    return r;
  endfunction

  // Called at a negedge: requests d0, then logs n cycles (index 0 = first
  // negedge after the accepting edge); at index i2 issues a one-cycle request d2.
  task automatic run(input int sel, input logic [7:0] d0, input int n, input int i2,
                     input logic [7:0] d2, output logic [127:0] txv,
                     output logic [127:0] bv, output int bcnt);
    txv = '1; bv = '0; bcnt = 0;
    if (sel == 1) begin data1 = d0; nd1 = 1'b1; end
    else          begin data2 = d0; nd2 = 1'b1; end
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      txv[i] = (sel == 1) ? tx1 : tx2;
      bv[i]  = (sel == 1) ? busy1 : busy2;
      bcnt  += int'(bv[i]);
      if (sel == 1) begin nd1 = (i == i2); if (i == i2) data1 = d2; end
      else          begin nd2 = (i == i2); if (i == i2) data2 = d2; end
      @(negedge clk);
    end
    nd1 = 1'b0; nd2 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; nd1 = 1'b0; nd2 = 1'b0; data1 = '0; data2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx1, busy1, fs1} !== {1'b1, 1'b0, 16'h0}) begin
      errors++; $display("FAIL reset_dut1 got tx/busy/fs=%b/%b/%h want 1/0/0000", tx1, busy1, fs1);
    end
    checks++;
    if ({tx2, busy2, fs2} !== {1'b1, 1'b0, 16'h0}) begin
      errors++; $display("FAIL reset_dut2 got tx/busy/fs=%b/%b/%h want 1/0/0000", tx2, busy2, fs2);
    end
    nd1 = 1'b1; data1 = 8'hC3;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL req_in_reset got busy=%b want 0", busy1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy1, tx1} !== 2'b10) begin
      errors++; $display("FAIL first_edge_accept got busy/tx=%b/%b want 1/0", busy1, tx1);
    end
    nd1 = 1'b0;
    repeat (44) @(negedge clk);
    checks++;
    if ({busy1, tx1, fs1} !== {1'b0, 1'b1, 16'd1}) begin
      errors++; $display("FAIL after_first got busy/tx/fs=%b/%b/%h want 0/1/0001", busy1, tx1, fs1);
    end
  endtask

  task automatic test_single;
    logic [127:0] txv, bv; int bc;
    run(1, 8'hA5, 44, -1, 8'h00, txv, bv, bc);
    checks++;
    if (txv !== frame(8'hA5, 1, 0)) begin
      errors++; $display("FAIL single_tx got %h want %h", txv, frame(8'hA5, 1, 0));
    end
    checks++;
    if (bc != 40) begin
      errors++; $display("FAIL single_busy_len got %0d want 40", bc);
    end
    checks++;
    if (fs1 !== 16'd2) begin
      errors++; $display("FAIL single_frames got %h want 0002", fs1);
    end
  endtask

  task automatic test_handshake;
    logic [127:0] txv, bv; int bc;
    run(1, 8'hA5, 44, 4, 8'hFF, txv, bv, bc);
    checks++;
    if (bv[0] !== 1'b1) begin
      errors++; $display("FAIL hs_busy_next got %b want 1", bv[0]);
    end
    checks++;
    if (txv !== frame(8'hA5, 1, 0)) begin
      errors++; $display("FAIL hs_ignored got %h want %h", txv, frame(8'hA5, 1, 0));
    end
    checks++;
    if (bc != 40 || fs1 !== 16'd3) begin
      errors++; $display("FAIL hs_len_frames got %0d/%h want 40/0003", bc, fs1);
    end
  endtask

  task automatic test_stop_edge;
    logic [127:0] txv, bv; int bc;
    run(1, 8'hA5, 48, 39, 8'h0F, txv, bv, bc);
    checks++;
    if (txv !== frame(8'hA5, 1, 0) || bc != 40) begin
      errors++; $display("FAIL stop_edge_req got %h/%0d want %h/40", txv, bc, frame(8'hA5, 1, 0));
    end
    checks++;
    if (fs1 !== 16'd4) begin
      errors++; $display("FAIL stop_edge_frames got %h want 0004", fs1);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] txv, bv, ex; int bc;
    ex = frame(8'h00, 1, 0) & frame(8'hFF, 1, 41);
    run(1, 8'h00, 84, 40, 8'hFF, txv, bv, bc);
    checks++;
    if (bv[40] !== 1'b0 || bv[41] !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got busy[40]/[41]=%b/%b want 0/1", bv[40], bv[41]);
    end
    checks++;
    if (txv !== ex) begin
      errors++; $display("FAIL b2b_tx got %h want %h", txv, ex);
    end
    checks++;
    if (bc != 80 || fs1 !== 16'd6) begin
      errors++; $display("FAIL b2b_len_frames got %0d/%h want 80/0006", bc, fs1);
    end
  endtask

  task automatic test_stop2;
    logic [127:0] txv, bv; int bc;
    run(2, 8'h3C, 48, -1, 8'h00, txv, bv, bc);
    checks++;
    if (txv !== frame(8'h3C, 2, 0)) begin
      errors++; $display("FAIL stop2_tx got %h want %h", txv, frame(8'h3C, 2, 0));
    end
    checks++;
    if (bc != 44 || fs2 !== 16'd1) begin
      errors++; $display("FAIL stop2_len_frames got %0d/%h want 44/0001", bc, fs2);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] txv, bv; int bc;
    run(1, 8'h00, 17, -1, 8'h00, txv, bv, bc);
    checks++;
    if ({tx1, busy1} !== 2'b01) begin
      errors++; $display("FAIL mid_pre got tx/busy=%b/%b want 0/1", tx1, busy1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx1, busy1, fs1} !== {1'b1, 1'b0, 16'd0}) begin
      errors++; $display("FAIL mid_abort got tx/busy/fs=%b/%b/%h want 1/0/0000", tx1, busy1, fs1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1, 8'h55, 44, -1, 8'h00, txv, bv, bc);
    checks++;
    if (txv !== frame(8'h55, 1, 0) || bc != 40) begin
      errors++; $display("FAIL mid_after got %h/%0d want %h/40", txv, bc, frame(8'h55, 1, 0));
    end
    checks++;
    if (fs1 !== 16'd1) begin
      errors++; $display("FAIL mid_frames got %h want 0001", fs1);
    end
  endtask

  task automatic test_wrap;
    logic [127:0] txv, bv; int bc;
    force dut1.r_frames = 16'hFFFF;
    @(negedge clk);
    release dut1.r_frames;
    @(negedge clk);
    checks++;
    if (fs1 !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload got %h want ffff", fs1);
    end
    run(1, 8'hA5, 44, -1, 8'h00, txv, bv, bc);
    checks++;
    if (fs1 !== 16'h0000) begin
      errors++; $display("FAIL wrap_value got %h want 0000", fs1);
    end
    checks++;
    if (txv !== frame(8'hA5, 1, 0) || bc != 40) begin
      errors++; $display("FAIL wrap_frame got %h/%0d want %h/40", txv, bc, frame(8'hA5, 1, 0));
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_handshake;
    test_stop_edge;
    test_back_to_back;
    test_stop2;
    test_reset_mid;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
